// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//
// Sequences program-counter redirection for the pipelined datapath. Chooses
// between ID-stage jumps (J/JAL direct, JR register) and EX-stage taken
// branches. It drives the PC load select and target and the pipeline-register
// flush lines. It also counts redirects for loop performance measurement.
//
// Ports:
//   Clk              rising-edge clock
//   Reset            synchronous, active-high reset
//   Stall            hazard-unit stall; ID jump requests are held off while high
//   ID_Jump          direct jump (J/JAL) in ID
//   ID_JumpReg       JR in ID
//   ID_JumpIndex     instruction[25:0] of the ID instruction
//   ID_PCPlus4       PC+4 of the ID instruction
//   ID_RegRS         forwarded rs value for JR
//   EX_BranchTaken   branch resolved taken in EX
//   EX_BranchTarget  resolved branch target
//   RedirectValid    PC loads RedirectTarget at the end of this cycle
//   RedirectTarget   registered target address (held while idle)
//   FlushIFID        clear IF/ID register
//   FlushIDEX        clear ID/EX register
//   FlushEXMEM       clear EX/MEM register (branch redirects only)
//   Busy             high while a redirect is in progress
//   RedirectCount    number of redirects issued, saturating at all-ones
//
// All outputs are registered. No path runs combinationally from an input to
// an output.

module pc_redirect_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Stall,
   input  logic             ID_Jump,
   input  logic             ID_JumpReg,
   input  logic [25:0]      ID_JumpIndex,
   input  logic [31:0]      ID_PCPlus4,
   input  logic [31:0]      ID_RegRS,
   input  logic             EX_BranchTaken,
   input  logic [31:0]      EX_BranchTarget,
   output logic             RedirectValid,
   output logic [31:0]      RedirectTarget,
   output logic             FlushIFID,
   output logic             FlushIDEX,
   output logic             FlushEXMEM,
   output logic             Busy,
   output logic [CNT_W-1:0] RedirectCount
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REDIR_J = 2'd1,
      REDIR_B = 2'd2
   } state_t;

   state_t state;

   // Direct-jump target is pure concatenation: the upper nibble comes from
   // PC+4 and the low two bits are always zero. No adder is involved.
   logic [31:0] jump_target;
   assign jump_target = {ID_PCPlus4[31:28], ID_JumpIndex, 2'b00};

   // Only the upper nibble of PC+4 takes part in the direct-jump target.
   logic unused_pcplus4_low;
   assign unused_pcplus4_low = ^ID_PCPlus4[27:0];

   logic [CNT_W-1:0] count_next;
   assign count_next = (RedirectCount == '1) ? RedirectCount
                                              : RedirectCount + CNT_W'(1);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state          <= IDLE;
         RedirectValid  <= 1'b0;
         RedirectTarget <= '0;
         FlushIFID      <= 1'b0;
         FlushIDEX      <= 1'b0;
         FlushEXMEM     <= 1'b0;
         Busy           <= 1'b0;
         RedirectCount  <= '0;
      end else begin
         case (state)
            IDLE: begin
               // The EX branch is the older instruction. It wins over any ID
               // jump, and a stall does not hold it off.
               if (EX_BranchTaken) begin
                  state          <= REDIR_B;
                  RedirectTarget <= EX_BranchTarget;
                  RedirectValid  <= 1'b1;
                  FlushIFID      <= 1'b1;
                  FlushIDEX      <= 1'b1;
                  FlushEXMEM     <= 1'b1;
                  Busy           <= 1'b1;
                  RedirectCount  <= count_next;
               end else if (!Stall && (ID_JumpReg || ID_Jump)) begin
                  state          <= REDIR_J;
                  // JR takes priority if decode flags both jump kinds.
                  RedirectTarget <= ID_JumpReg ? ID_RegRS : jump_target;
                  RedirectValid  <= 1'b1;
                  FlushIFID      <= 1'b1;
                  FlushIDEX      <= 1'b1;
                  FlushEXMEM     <= 1'b0;
                  Busy           <= 1'b1;
                  RedirectCount  <= count_next;
               end else begin
                  state          <= IDLE;
                  RedirectValid  <= 1'b0;
                  FlushIFID      <= 1'b0;
                  FlushIDEX      <= 1'b0;
                  FlushEXMEM     <= 1'b0;
                  Busy           <= 1'b0;
               end
            end
            // A redirect lasts one cycle. Any request seen in that cycle is
            // wrong-path or the redirecting instruction itself, so it is
            // dropped.
            default: begin
               state          <= IDLE;
               RedirectValid  <= 1'b0;
               FlushIFID      <= 1'b0;
               FlushIDEX      <= 1'b0;
               FlushEXMEM     <= 1'b0;
               Busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

   logic        Clk;
   logic        Reset;
   logic        Stall;
   logic        ID_Jump;
   logic        ID_JumpReg;
   logic [25:0] ID_JumpIndex;
   logic [31:0] ID_PCPlus4;
   logic [31:0] ID_RegRS;
   logic        EX_BranchTaken;
   logic [31:0] EX_BranchTarget;

   logic        RedirectValid;
   logic [31:0] RedirectTarget;
   logic        FlushIFID;
   logic        FlushIDEX;
   logic        FlushEXMEM;
   logic        Busy;
   logic [15:0] RedirectCount;

   logic        s_RedirectValid;
   logic [31:0] s_RedirectTarget;
   logic        s_FlushIFID;
   logic        s_FlushIDEX;
   logic        s_FlushEXMEM;
   logic        s_Busy;
   logic [1:0]  s_RedirectCount;

   int n_assert = 0;
   int n_fail   = 0;

   pc_redirect_ctrl #(.CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall),
      .ID_Jump(ID_Jump), .ID_JumpReg(ID_JumpReg),
      .ID_JumpIndex(ID_JumpIndex), .ID_PCPlus4(ID_PCPlus4),
      .ID_RegRS(ID_RegRS),
      .EX_BranchTaken(EX_BranchTaken), .EX_BranchTarget(EX_BranchTarget),
      .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget),
      .FlushIFID(FlushIFID), .FlushIDEX(FlushIDEX), .FlushEXMEM(FlushEXMEM),
      .Busy(Busy), .RedirectCount(RedirectCount)
   );

   pc_redirect_ctrl #(.CNT_W(2)) dut_sat (
      .Clk(Clk), .Reset(Reset), .Stall(Stall),
      .ID_Jump(ID_Jump), .ID_JumpReg(ID_JumpReg),
      .ID_JumpIndex(ID_JumpIndex), .ID_PCPlus4(ID_PCPlus4),
      .ID_RegRS(ID_RegRS),
      .EX_BranchTaken(EX_BranchTaken), .EX_BranchTarget(EX_BranchTarget),
      .RedirectValid(s_RedirectValid), .RedirectTarget(s_RedirectTarget),
      .FlushIFID(s_FlushIFID), .FlushIDEX(s_FlushIDEX), .FlushEXMEM(s_FlushEXMEM),
      .Busy(s_Busy), .RedirectCount(s_RedirectCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Advance one edge, then sample away from it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [31:0] t,
                          input logic f1, input logic f2, input logic f3,
                          input logic b, input logic [31:0] c, input logic [31:0] cs);
      chk({tag, ".valid"},  32'(RedirectValid), 32'(v));
      chk({tag, ".target"}, RedirectTarget, t);
      chk({tag, ".fifid"},  32'(FlushIFID), 32'(f1));
      chk({tag, ".fidex"},  32'(FlushIDEX), 32'(f2));
      chk({tag, ".fexmem"}, 32'(FlushEXMEM), 32'(f3));
      chk({tag, ".busy"},   32'(Busy), 32'(b));
      chk({tag, ".count"},  32'(RedirectCount), c);
      chk({tag, ".scount"}, 32'(s_RedirectCount), cs);
      chk({tag, ".svalid"}, 32'(s_RedirectValid), 32'(v));
   endtask

   initial begin
      logic [1:0] sat_exp [5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      Reset = 1'b1; Stall = 1'b0; ID_Jump = 1'b0; ID_JumpReg = 1'b0;
      ID_JumpIndex = '0; ID_PCPlus4 = '0; ID_RegRS = '0;
      EX_BranchTaken = 1'b0; EX_BranchTarget = '0;

      // Reset state
      tick();
      tick();
      chk_all("reset", 0, 32'h0, 0, 0, 0, 0, 0, 0);
      Reset = 1'b0;

      // Direct jump target formation
      ID_Jump = 1'b1; ID_PCPlus4 = 32'h1000_0040; ID_JumpIndex = 26'h0000123;
      tick();
      chk_all("jdir", 1, 32'h1000_048C, 1, 1, 0, 1, 1, 1);
      ID_Jump = 1'b0;
      tick();
      chk_all("jdir_idle", 0, 32'h1000_048C, 0, 0, 0, 0, 1, 1);

      // JR
      ID_JumpReg = 1'b1; ID_RegRS = 32'h0040_0100;
      tick();
      chk_all("jr", 1, 32'h0040_0100, 1, 1, 0, 1, 2, 2);
      ID_JumpReg = 1'b0;
      tick();
      chk_all("jr_idle", 0, 32'h0040_0100, 0, 0, 0, 0, 2, 2);

      // JR held off by Stall, then accepted once Stall drops
      Stall = 1'b1; ID_JumpReg = 1'b1; ID_RegRS = 32'h0040_0200;
      tick();
      chk_all("jr_stall1", 0, 32'h0040_0100, 0, 0, 0, 0, 2, 2);
      tick();
      chk_all("jr_stall2", 0, 32'h0040_0100, 0, 0, 0, 0, 2, 2);
      Stall = 1'b0;
      tick();
      chk_all("jr_unstall", 1, 32'h0040_0200, 1, 1, 0, 1, 3, 3);
      ID_JumpReg = 1'b0;
      tick();
      chk_all("jr_unstall_idle", 0, 32'h0040_0200, 0, 0, 0, 0, 3, 3);

      // Branch beats a jump in the same edge, even under Stall
      EX_BranchTaken = 1'b1; EX_BranchTarget = 32'h0000_0200;
      ID_Jump = 1'b1; Stall = 1'b1;
      tick();
      chk_all("br_prio", 1, 32'h0000_0200, 1, 1, 1, 1, 4, 3);
      EX_BranchTaken = 1'b0; ID_Jump = 1'b0; Stall = 1'b0;
      tick();
      chk_all("br_prio_idle", 0, 32'h0000_0200, 0, 0, 0, 0, 4, 3);
      tick();
      chk_all("br_prio_nodup", 0, 32'h0000_0200, 0, 0, 0, 0, 4, 3);

      // JR wins over direct jump
      ID_Jump = 1'b1; ID_JumpIndex = 26'h3FF_FFFF; ID_PCPlus4 = 32'hF000_0000;
      ID_JumpReg = 1'b1; ID_RegRS = 32'h1234_5678;
      tick();
      chk_all("jr_over_j", 1, 32'h1234_5678, 1, 1, 0, 1, 5, 3);
      ID_JumpReg = 1'b0; ID_Jump = 1'b0;
      tick();

      // Direct jump with all index bits set: no carry into the upper nibble
      ID_Jump = 1'b1; ID_PCPlus4 = 32'hFFFF_FFFC; ID_JumpIndex = 26'h3FF_FFFF;
      tick();
      chk_all("jdir_max", 1, 32'hFFFF_FFFC, 1, 1, 0, 1, 6, 3);
      ID_Jump = 1'b0;
      ID_PCPlus4 = 32'h5000_0000; ID_JumpIndex = 26'h0000001;
      tick();
      // Holding the target in IDLE means it does not track the inputs.
      chk_all("jdir_max_idle", 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 6, 3);

      // Branch held continuously: valid 0,1,0,1,0,1
      EX_BranchTaken = 1'b1; EX_BranchTarget = 32'h0000_0300;
      chk_all("hold0", 0, 32'hFFFF_FFFC, 0, 0, 0, 0, 6, 3);
      tick();
      chk_all("hold1", 1, 32'h0000_0300, 1, 1, 1, 1, 7, 3);
      tick();
      chk_all("hold2", 0, 32'h0000_0300, 0, 0, 0, 0, 7, 3);
      tick();
      chk_all("hold3", 1, 32'h0000_0300, 1, 1, 1, 1, 8, 3);
      tick();
      chk_all("hold4", 0, 32'h0000_0300, 0, 0, 0, 0, 8, 3);
      tick();
      chk_all("hold5", 1, 32'h0000_0300, 1, 1, 1, 1, 9, 3);

      // Reset during REDIR_B with the branch request still pending
      Reset = 1'b1;
      tick();
      chk_all("reset_redir", 0, 32'h0, 0, 0, 0, 0, 0, 0);
      Reset = 1'b0; EX_BranchTaken = 1'b0;
      tick();
      chk_all("reset_redir_idle", 0, 32'h0, 0, 0, 0, 0, 0, 0);

      // Five redirects: the 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         ID_Jump = 1'b1; ID_PCPlus4 = 32'h0; ID_JumpIndex = 26'(i + 1);
         tick();
         chk_all($sformatf("sat%0d", i), 1, 32'((i + 1) * 4), 1, 1, 0, 1,
                 32'(i + 1), 32'(sat_exp[i]));
         ID_Jump = 1'b0;
         tick();
         chk($sformatf("sat%0d_idle.valid", i), 32'(RedirectValid), 32'h0);
         chk($sformatf("sat%0d_idle.scount", i), 32'(s_RedirectCount), 32'(sat_exp[i]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequences program-counter redirection for the pipelined datapath.
- Arbitrates between ID-stage jumps (J/JAL direct, JR register) and EX-stage taken branches, and forms the jump target from the 26-bit index shifted left 2 and concatenated with PC+4[31:28].
- Drives the PC load select/target and the pipeline-register flush lines, and counts redirects for SAD-loop performance measurement.
- Sits between the ID/EX control decode and the PC / pipeline-register write logic.

Parameters:
- CNT_W, 16, width of saturating redirect counter

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Stall  input  1  hazard-unit stall; ID jump requests not accepted while high
- ID_Jump  input  1  direct jump (J/JAL) in ID
- ID_JumpReg  input  1  JR in ID
- ID_JumpIndex  input  26  instruction[25:0] of ID instruction
- ID_PCPlus4  input  32  PC+4 of ID instruction
- ID_RegRS  input  32  forwarded rs value for JR
- EX_BranchTaken  input  1  branch resolved taken in EX
- EX_BranchTarget  input  32  resolved branch target
- RedirectValid  output  1  PC loads RedirectTarget at end of this cycle
- RedirectTarget  output  32  registered target address
- FlushIFID  output  1  clear IF/ID register
- FlushIDEX  output  1  clear ID/EX register
- FlushEXMEM  output  1  clear EX/MEM register (branch redirects only)
- Busy  output  1  high while state != IDLE
- RedirectCount  output  CNT_W  number of redirects issued, saturating

Behaviour:
- Reset (sync, Clk edge with Reset=1): state=IDLE; all 1-bit outputs 0; RedirectTarget=0; RedirectCount=0. Reset overrides any request or in-progress redirect in the same edge.
- Outputs are registered, with no combinational input-to-output paths.
- States: IDLE, REDIR_J, REDIR_B.
- IDLE sampling, by priority at each edge:
  - EX_BranchTaken=1 -> REDIR_B, RedirectTarget<=EX_BranchTarget. Accepted regardless of Stall; the older instruction wins over any ID jump in the same edge.
  - Else Stall=0 and ID_JumpReg=1 -> REDIR_J, RedirectTarget<=ID_RegRS.
  - Else Stall=0 and ID_Jump=1 -> REDIR_J, RedirectTarget<={ID_PCPlus4[31:28], ID_JumpIndex, 2'b00}.
  - ID_Jump and ID_JumpReg both high: JR wins.
  - Else stay IDLE.
- Latency: a request sampled at edge N gives RedirectValid=1 for exactly one cycle (N to N+1).
- REDIR_J, one cycle: RedirectValid=1, FlushIFID=1, FlushIDEX=1, FlushEXMEM=0, Busy=1. Returns to IDLE.
- REDIR_B, one cycle: RedirectValid=1, FlushIFID=1, FlushIDEX=1, FlushEXMEM=1, Busy=1. Returns to IDLE.
- All requests presented while in REDIR_J/REDIR_B are wrong-path or the redirecting instruction itself, and are ignored. There are no back-to-back redirects, so the minimum spacing is 2 cycles.
- The target is held stable in IDLE: RedirectTarget keeps its last value, and RedirectValid/Flush*=0.
- RedirectCount increments by 1 on each entry to REDIR_J/REDIR_B and saturates at 2^CNT_W-1 (no wrap).
- Target arithmetic is pure bit concatenation: no carry, and bits [1:0] of a direct-jump target are always 00. JR/branch targets are passed unmodified; misalignment is not checked.

Test Plan:
- Reset -> all outputs 0, RedirectCount=0. Then ID_Jump=1, ID_PCPlus4=0x1000_0040, ID_JumpIndex=0x0000123 -> next cycle RedirectValid=1, RedirectTarget=0x1000_048C, FlushIFID=FlushIDEX=1, FlushEXMEM=0, RedirectCount=1.
- ID_JumpReg=1, ID_RegRS=0x0040_0100, Stall=0 -> next cycle target 0x0040_0100, jump-type flushes. Repeat with Stall=1 -> no redirect; drop Stall -> redirect the following cycle.
- Same edge EX_BranchTaken=1 (target 0x0000_0200), ID_Jump=1, Stall=1 -> branch redirect to 0x0000_0200 with FlushEXMEM=1. The jump is dropped (no second redirect while its inputs are held only that cycle).
- Requests held high continuously for 6 cycles -> RedirectValid pattern 0,1,0,1,0,1 (the leading 0 is the sampling edge, then alternating). Count increments every 2 cycles.
- Reset asserted in a REDIR_B cycle -> next cycle all outputs 0, state IDLE. A pending EX_BranchTaken at that edge is ignored.
- CNT_W=2 override, 5 redirects -> RedirectCount 1,2,3,3,3.
